// File: rtl/gardner_ted_filter.sv
// Gardner timing-error detector with a proportional-integral loop filter.
// Captures on-time and mid-symbol I/Q samples around the corrector's strobe,
// forms the Gardner error once per symbol and publishes the negated,
// filtered error that the corrector adds to its sampling increment.
module gardner_ted_filter #(
  parameter int WIDTH     = 16,
  parameter int HALF_SYM  = 16,
  parameter int KP_SHIFT  = 4,
  parameter int KI_SHIFT  = 8,
  parameter int ACC_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    strobe,
  input  logic signed [WIDTH-1:0] I_32M,
  input  logic signed [WIDTH-1:0] Q_32M,
  output logic signed [WIDTH-1:0] error_n,
  output logic                    err_valid,
  output logic                    sync_err
);

  // Product width: (WIDTH+1)-bit difference times WIDTH-bit sample.
  localparam int PROD_W = 2 * WIDTH + 1;
  // Sum of the I and Q products; exact for any input.
  localparam int TED_W  = 2 * WIDTH + 2;
  // Error after dropping WIDTH-1 fraction bits.
  localparam int TS_W   = WIDTH + 3;
  // Integrator update headroom and filter output headroom.
  localparam int ACC_X  = ACC_WIDTH + 1;
  localparam int SUM_W  = ACC_WIDTH + 2;

  localparam logic [7:0] HALF_CNT = 8'(HALF_SYM);

  localparam logic signed [ACC_X-1:0] ACC_MAX = {2'b00, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_X-1:0] ACC_MIN = -ACC_MAX;
  localparam logic signed [SUM_W-1:0] OUT_MAX = SUM_W'({1'b0, {(WIDTH-1){1'b1}}});
  localparam logic signed [SUM_W-1:0] OUT_MIN = -OUT_MAX;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_MID,
    S_WAIT_ON,
    S_MUL,
    S_FILT
  } state_t;

  state_t state, state_nxt;

  logic [7:0] cnt;

  logic cap_prev, cap_mid, cap_cur, shift_cur;
  logic do_mul, do_filt, accept, viol;

  logic signed [WIDTH-1:0] prev_i, prev_q, mid_i, mid_q, cur_i, cur_q;

  logic signed [WIDTH:0]     diff_i, diff_q;
  logic signed [PROD_W-1:0]  prod_i, prod_q;
  logic signed [TED_W-1:0]   ted_sum, ted;
  logic signed [TS_W-1:0]    ted_s, p_term, i_term;
  logic signed [ACC_X-1:0]   integ_sum;
  logic signed [ACC_WIDTH-1:0] integ, integ_new;
  logic signed [SUM_W-1:0]   filt_sum, filt_neg;
  logic                      unused_ted_lsb;

  // Symmetric clip of the integrator update to +/-(2^(ACC_WIDTH-1)-1).
  function automatic logic signed [ACC_WIDTH-1:0] sat_acc(input logic signed [ACC_X-1:0] x);
    logic signed [ACC_X-1:0] y;
    if (x > ACC_MAX)      y = ACC_MAX;
    else if (x < ACC_MIN) y = ACC_MIN;
    else                  y = x;
    return y[ACC_WIDTH-1:0];
  endfunction

  // Symmetric clip of the output; the most negative code is never produced.
  function automatic logic signed [WIDTH-1:0] sat_w(input logic signed [SUM_W-1:0] x);
    logic signed [SUM_W-1:0] y;
    if (x > OUT_MAX)      y = OUT_MAX;
    else if (x < OUT_MIN) y = OUT_MIN;
    else                  y = x;
    return y[WIDTH-1:0];
  endfunction

  // Next-state and capture decode; a strobe in S_WAIT_MID always resyncs.
  always_comb begin
    state_nxt = state;
    cap_prev  = 1'b0;
    cap_mid   = 1'b0;
    cap_cur   = 1'b0;
    shift_cur = 1'b0;
    do_mul    = 1'b0;
    do_filt   = 1'b0;
    accept    = 1'b0;
    viol      = 1'b0;
    if (!en) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (strobe) begin
            cap_prev  = 1'b1;
            accept    = 1'b1;
            state_nxt = S_WAIT_MID;
          end
        end
        S_WAIT_MID: begin
          if (strobe) begin
            cap_prev = 1'b1;
            accept   = 1'b1;
            viol     = 1'b1;
          end else if (cnt == HALF_CNT) begin
            cap_mid   = 1'b1;
            state_nxt = S_WAIT_ON;
          end
        end
        S_WAIT_ON: begin
          if (strobe) begin
            cap_cur   = 1'b1;
            accept    = 1'b1;
            state_nxt = S_MUL;
          end
        end
        S_MUL: begin
          do_mul    = 1'b1;
          viol      = strobe;
          state_nxt = S_FILT;
        end
        S_FILT: begin
          do_filt   = 1'b1;
          viol      = strobe;
          shift_cur = 1'b1;
          state_nxt = S_WAIT_MID;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Cycles since the last accepted strobe, saturating so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt <= '0;
    else if (accept)         cnt <= 8'd1;
    else if (cnt != 8'hFF)   cnt <= cnt + 8'd1;
  end

  // ---- Capture stage: previous, mid-symbol and current samples ----
  // Sample capture; the closing sample becomes the next symbol's previous one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_i <= '0;
      prev_q <= '0;
      mid_i  <= '0;
      mid_q  <= '0;
      cur_i  <= '0;
      cur_q  <= '0;
    end else begin
      if (cap_prev) begin
        prev_i <= I_32M;
        prev_q <= Q_32M;
      end else if (shift_cur) begin
        prev_i <= cur_i;
        prev_q <= cur_q;
      end
      if (cap_mid) begin
        mid_i <= I_32M;
        mid_q <= Q_32M;
      end
      if (cap_cur) begin
        cur_i <= I_32M;
        cur_q <= Q_32M;
      end
    end
  end

  // ---- Multiply stage: Gardner error, full precision ----
  always_comb begin
    diff_i  = {prev_i[WIDTH-1], prev_i} - {cur_i[WIDTH-1], cur_i};
    diff_q  = {prev_q[WIDTH-1], prev_q} - {cur_q[WIDTH-1], cur_q};
    prod_i  = PROD_W'(mid_i) * PROD_W'(diff_i);
    prod_q  = PROD_W'(mid_q) * PROD_W'(diff_q);
    ted_sum = TED_W'(prod_i) + TED_W'(prod_q);
  end

  // Error register, loaded once per symbol.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ted <= '0;
    else if (do_mul) ted <= ted_sum;
  end

  // ---- Filter stage: scale, integrate, negate and clip ----
  always_comb begin
    ted_s          = ted[TED_W-1:WIDTH-1];
    unused_ted_lsb = ^ted[WIDTH-2:0];
    p_term         = ted_s >>> KP_SHIFT;
    i_term         = ted_s >>> KI_SHIFT;
    integ_sum      = ACC_X'(integ) + ACC_X'(i_term);
    integ_new      = sat_acc(integ_sum);
    filt_sum       = SUM_W'(p_term) + SUM_W'(integ_new);
    filt_neg       = -filt_sum;
  end

  // Integrator and output; both hold while the loop is disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      integ   <= '0;
      error_n <= '0;
    end else if (do_filt) begin
      integ   <= integ_new;
      error_n <= sat_w(filt_neg);
    end
  end

  // Output strobes, registered alongside error_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_valid <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      err_valid <= do_filt;
      sync_err  <= viol;
    end
  end

endmodule

// File: tb/tb_gardner_ted_filter.sv
// Scoreboard bench for gardner_ted_filter: directed symbol sequences push
// hand-computed error_n values and sync_err times; a monitor pops and compares.
module tb_gardner_ted_filter;

  logic               clk;
  logic               rst_n;
  logic               en;
  logic               strobe;
  logic signed [15:0] I_32M;
  logic signed [15:0] Q_32M;
  logic signed [15:0] error_n;
  logic               err_valid;
  logic               sync_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int val;
    int cyc;
  } exp_t;

  exp_t eq[$];
  int   sq[$];
  exp_t e;

  gardner_ted_filter #(
    .WIDTH(16), .HALF_SYM(16), .KP_SHIFT(4), .KI_SHIFT(8), .ACC_WIDTH(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .strobe(strobe),
    .I_32M(I_32M), .Q_32M(Q_32M),
    .error_n(error_n), .err_valid(err_valid), .sync_err(sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every err_valid / sync_err pulse must match the head of its queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (err_valid) begin
        checks++;
        if (eq.size() == 0) begin
          errors++;
          $display("FAIL err_valid_unexpected cyc=%0d error_n=%0d required=no pulse", cyc, error_n);
        end else begin
          e = eq.pop_front();
          if (error_n !== e.val || cyc != e.cyc) begin
            errors++;
            $display("FAIL error_n actual=%0d@%0d required=%0d@%0d", error_n, cyc, e.val, e.cyc);
          end
        end
      end else if (eq.size() > 0 && cyc > eq[0].cyc) begin
        checks++;
        errors++;
        $display("FAIL err_valid_missing cyc=%0d required=%0d@%0d", cyc, eq[0].val, eq[0].cyc);
        void'(eq.pop_front());
      end
      if (sync_err) begin
        checks++;
        if (sq.size() == 0) begin
          errors++;
          $display("FAIL sync_err_unexpected cyc=%0d required=no pulse", cyc);
        end else if (sq[0] != cyc) begin
          errors++;
          $display("FAIL sync_err_time actual=%0d required=%0d", cyc, sq[0]);
          void'(sq.pop_front());
        end else begin
          void'(sq.pop_front());
        end
      end else if (sq.size() > 0 && cyc > sq[0]) begin
        checks++;
        errors++;
        $display("FAIL sync_err_missing cyc=%0d required=%0d", cyc, sq[0]);
        void'(sq.pop_front());
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // One 32-cycle symbol: strobe with the on-time sample in cycle 0, mid sample
  // in cycle 16, filler elsewhere. Optional extra strobes in cycles 1 and 2.
  task automatic sym(input int oi, input int oq, input int mi, input int mq,
                     input bit exp_out, input int exp_val,
                     input bit early, input bit extra);
    for (int j = 0; j < 32; j++) begin
      @(posedge clk); #1;
      strobe = (j == 0) || (extra && (j == 1 || j == 2));
      if (j == 0) begin
        I_32M = 16'(oi);
        Q_32M = 16'(oq);
        if (exp_out) eq.push_back('{exp_val, cyc + 3});
        if (early)   sq.push_back(cyc + 1);
      end else if (j == 16) begin
        I_32M = 16'(mi);
        Q_32M = 16'(mq);
      end else begin
        I_32M = 16'sd1111;
        Q_32M = -16'sd2222;
      end
      if (extra && (j == 1 || j == 2)) sq.push_back(cyc + 1);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    en     = 1'b1;
    strobe = 1'b0;
    I_32M  = '0;
    Q_32M  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_error_n", error_n, 0);
    chk("reset_err_valid", err_valid, 0);
    chk("reset_sync_err", sync_err, 0);
    rst_n = 1'b1;

    // Ideal timing: zero crossings at mid, ted = 0.
    sym( 16384, 0,     0, 0, 0,    0, 0, 0);
    sym(-16384, 0,     0, 0, 1,    0, 0, 0);
    sym( 16384, 0,  8192, 0, 1,    0, 0, 0);
    // Off-centre timing, two consecutive symbols.
    sym(-16384, 0, -8192, 0, 1, -544, 0, 0);
    sym( 16384, 0,  8192, 0, 1, -576, 0, 0);

    // Loop disabled: strobes ignored, output held.
    @(posedge clk); #1; en = 1'b0;
    sym(-16384, 0, -8192, 0, 0, 0, 0, 0);
    sym( 16384, 0,  8192, 0, 0, 0, 0, 0);
    chk("en0_hold_error_n", error_n, -576);
    @(posedge clk); #1; en = 1'b1;
    // Restart from idle: integrator 64 -> 96.
    sym( 16384, 0,  8192, 0, 0,    0, 0, 0);
    sym(-16384, 0,     0, 0, 1, -608, 0, 0);

    // Closing strobe, then asynchronous reset while err_valid is high.
    @(posedge clk); #1; strobe = 1'b1; I_32M = 16'sd16384; Q_32M = '0;
    @(posedge clk); #1; strobe = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("pre_reset_err_valid", err_valid, 1);
    chk("pre_reset_error_n", error_n, -96);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset_error_n", error_n, 0);
    chk("async_reset_err_valid", err_valid, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Full scale: error_n = 8192 + 512k, clipping at 32767 from k = 48.
    for (int k = 1; k <= 50; k++) begin
      @(posedge clk); #1; en = 1'b0;
      @(posedge clk); #1; en = 1'b1;
      sym( 32767,  32767, -32768, -32768, 0, 0, 0, 0);
      sym(-32768, -32768,      0,      0, 1,
          (8192 + 512 * k > 32767) ? 32767 : 8192 + 512 * k, 0, 0);
    end

    // Early strobe at cnt = 10 resyncs the symbol.
    do_reset();
    @(posedge clk); #1; strobe = 1'b1; I_32M = 16'sd999; Q_32M = '0;
    for (int j = 1; j < 10; j++) begin
      @(posedge clk); #1; strobe = 1'b0; I_32M = 16'sd1111; Q_32M = -16'sd2222;
    end
    sym( 16384, 0,  8192, 0, 0,    0, 1, 0);
    sym(-16384, 0, -8192, 0, 1, -544, 0, 0);
    // Strobes during the multiply and filter cycles are flagged and ignored.
    sym( 16384, 0,  8192, 0, 1, -576, 0, 1);
    sym(-16384, 0,     0, 0, 1, -608, 0, 0);

    repeat (10) @(posedge clk);
    #1;
    chk("pending_error_outputs", eq.size(), 0);
    chk("pending_sync_pulses", sq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
